// File: rtl/fifo_pkg.sv
// Shared helpers for the synchronous FIFO family: pointer wrap and
// elaboration-time parameter legality checks.
package fifo_pkg;

    // Wraps from depth-1 back to 0, so non-power-of-two depths work.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

    function automatic bit width_ok(input int width);
        return width >= 1;
    endfunction

    function automatic bit depth_ok(input int depth);
        return depth >= 2;
    endfunction

    function automatic bit af_thresh_ok(input int af, input int depth);
        return (af >= 1) && (af <= depth);
    endfunction

    function automatic bit ae_thresh_ok(input int ae, input int depth);
        return (ae >= 0) && (ae <= depth - 1);
    endfunction

endpackage

// File: rtl/sfifo_ram.sv
// Simple dual-port storage for sfifo_ext: registered write, asynchronous read.
module sfifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    // Contents are never cleared; the FIFO pointers alone define validity.
    (* ram_style = "block" *) logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sfifo_ext.sv
// Single-clock first-word-fall-through FIFO with thresholds, flush and
// sticky overflow/underflow flags.
module sfifo_ext
    import fifo_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 32,
    parameter int AF_THRESH    = DEPTH - 2,
    parameter int AE_THRESH    = 2,
    parameter int PASS_ON_FULL = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    output logic                       full,
    output logic                       almost_full,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    input  logic                       flush,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("sfifo_ext: WIDTH must be at least 1");
    end
    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("sfifo_ext: DEPTH must be at least 2");
    end
    if (!af_thresh_ok(AF_THRESH, DEPTH)) begin : g_bad_af
        $error("sfifo_ext: AF_THRESH must lie in 1..DEPTH");
    end
    if (!ae_thresh_ok(AE_THRESH, DEPTH)) begin : g_bad_ae
        $error("sfifo_ext: AE_THRESH must lie in 0..DEPTH-1");
    end

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          pop_acc, push_acc, ram_we;

    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_THRESH));
    assign almost_empty = (count_q <= CW'(AE_THRESH));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign pop_acc  = pop && !empty;
    assign push_acc = push && (!full || ((PASS_ON_FULL != 0) && pop_acc));
    // Reset and flush both suppress the write, not just the pointer update.
    assign ram_we   = push_acc && !flush && !rst;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr_d = PW'(ptr_inc(32'(wr_ptr_q), DEPTH));
            end
            if (pop_acc) begin
                rd_ptr_d = PW'(ptr_inc(32'(rd_ptr_q), DEPTH));
            end
            if (push_acc && !pop_acc) begin
                count_d = count_q + CW'(1);
            end else if (pop_acc && !push_acc) begin
                count_d = count_q - CW'(1);
            end
            // A fresh error in the same cycle outranks clr_err.
            overflow_d  = (overflow_q && !clr_err) || (push && !push_acc);
            underflow_d = (underflow_q && !clr_err) || (pop && !pop_acc);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    sfifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (push_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (pop_data)
    );

endmodule

// File: tb/tb_sfifo_ext.sv
// Bench for sfifo_ext: two instances (pass-on-full on/off) share stimulus
// and are compared against queue-based reference models.
module tb_sfifo_ext;

    localparam int D = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, push, pop, flush, clr_err;
    logic [7:0] push_data;

    logic       full_a, afull_a, empty_a, aempty_a, ovf_a, unf_a;
    logic [7:0] pop_data_a;
    logic [2:0] count_a;
    logic       full_b, afull_b, empty_b, aempty_b, ovf_b, unf_b;
    logic [7:0] pop_data_b;
    logic [2:0] count_b;

    sfifo_ext #(.WIDTH(8), .DEPTH(D), .AF_THRESH(4), .AE_THRESH(1), .PASS_ON_FULL(1)) dut (
        .clk(clk), .rst(rst), .push(push), .push_data(push_data),
        .full(full_a), .almost_full(afull_a), .pop(pop), .pop_data(pop_data_a),
        .empty(empty_a), .almost_empty(aempty_a), .count(count_a), .flush(flush),
        .overflow(ovf_a), .underflow(unf_a), .clr_err(clr_err)
    );

    sfifo_ext #(.WIDTH(8), .DEPTH(D), .AF_THRESH(4), .AE_THRESH(1), .PASS_ON_FULL(0)) dut_nopass (
        .clk(clk), .rst(rst), .push(push), .push_data(push_data),
        .full(full_b), .almost_full(afull_b), .pop(pop), .pop_data(pop_data_b),
        .empty(empty_b), .almost_empty(aempty_b), .count(count_b), .flush(flush),
        .overflow(ovf_b), .underflow(unf_b), .clr_err(clr_err)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [7:0] mqa[$];
    logic [7:0] mqb[$];
    logic       m_ovf_a, m_unf_a, m_ovf_b, m_unf_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit pa, ua, pb, ub;
        if (rst || flush) begin
            mqa.delete(); mqb.delete();
            m_ovf_a = 0; m_unf_a = 0; m_ovf_b = 0; m_unf_b = 0;
        end else begin
            pa = pop && (mqa.size() != 0);
            ua = push && ((mqa.size() < D) || pa);
            pb = pop && (mqb.size() != 0);
            ub = push && (mqb.size() < D);
            if (pa) void'(mqa.pop_front());
            if (ua) mqa.push_back(push_data);
            if (pb) void'(mqb.pop_front());
            if (ub) mqb.push_back(push_data);
            m_ovf_a = (m_ovf_a && !clr_err) || (push && !ua);
            m_unf_a = (m_unf_a && !clr_err) || (pop && !pa);
            m_ovf_b = (m_ovf_b && !clr_err) || (push && !ub);
            m_unf_b = (m_unf_b && !clr_err) || (pop && !pb);
        end
    endtask

    task automatic check_all();
        int sa, sb;
        sa = mqa.size();
        sb = mqb.size();
        check("count_a", 32'(count_a), sa);
        check("full_a", 32'(full_a), 32'(sa == D));
        check("afull_a", 32'(afull_a), 32'(sa >= 4));
        check("empty_a", 32'(empty_a), 32'(sa == 0));
        check("aempty_a", 32'(aempty_a), 32'(sa <= 1));
        check("ovf_a", 32'(ovf_a), 32'(m_ovf_a));
        check("unf_a", 32'(unf_a), 32'(m_unf_a));
        if (sa != 0) check("data_a", 32'(pop_data_a), 32'(mqa[0]));
        check("count_b", 32'(count_b), sb);
        check("full_b", 32'(full_b), 32'(sb == D));
        check("afull_b", 32'(afull_b), 32'(sb >= 4));
        check("empty_b", 32'(empty_b), 32'(sb == 0));
        check("aempty_b", 32'(aempty_b), 32'(sb <= 1));
        check("ovf_b", 32'(ovf_b), 32'(m_ovf_b));
        check("unf_b", 32'(unf_b), 32'(m_unf_b));
        if (sb != 0) check("data_b", 32'(pop_data_b), 32'(mqb[0]));
    endtask

    // Inputs change on the falling edge; outputs are compared on the next one.
    task automatic cycle(input logic i_push, input logic [7:0] i_data, input logic i_pop,
                         input logic i_flush, input logic i_clr, input logic i_rst);
        push = i_push; push_data = i_data; pop = i_pop;
        flush = i_flush; clr_err = i_clr; rst = i_rst;
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        cycle(0, 8'h00, 0, 0, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; push = 0; pop = 0; flush = 0; clr_err = 0; push_data = '0;
        m_ovf_a = 0; m_unf_a = 0; m_ovf_b = 0; m_unf_b = 0;
        @(negedge clk);
        do_reset();
        do_reset();
        check("rst_empty", 32'(empty_a), 1);
        check("rst_aempty", 32'(aempty_a), 1);

        // Fill, drain, then keep cycling so both pointers wrap.
        for (int i = 0; i < D; i++) cycle(1, 8'(8'h11 + i), 0, 0, 0, 0);
        check("fill_full", 32'(full_a), 1);
        for (int i = 0; i < D; i++) cycle(0, 8'h00, 1, 0, 0, 0);
        check("drain_empty", 32'(empty_a), 1);
        for (int i = 0; i < 7; i++) cycle(1, 8'(8'h30 + i), (i > 1) ? 1'b1 : 1'b0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1, 0, 0, 0);

        // Push together with pop on a full FIFO.
        do_reset();
        for (int i = 0; i < D; i++) cycle(1, 8'(8'h11 + i), 0, 0, 0, 0);
        cycle(1, 8'h66, 1, 0, 0, 0);
        check("pass_full", 32'(full_a), 1);
        check("pass_ovf", 32'(ovf_a), 0);
        check("nopass_ovf", 32'(ovf_b), 1);
        check("nopass_count", 32'(count_b), 4);
        for (int i = 0; i < D; i++) cycle(0, 8'h00, 1, 0, 0, 0);

        // Underflow and clr_err priority.
        do_reset();
        cycle(0, 8'h00, 1, 0, 0, 0);
        check("unf_set", 32'(unf_a), 1);
        cycle(0, 8'h00, 1, 0, 1, 0);
        check("unf_keep", 32'(unf_a), 1);
        cycle(0, 8'h00, 0, 0, 1, 0);
        check("unf_clr", 32'(unf_a), 0);

        // Simultaneous push/pop on empty: no bypass.
        do_reset();
        cycle(1, 8'hA5, 1, 0, 0, 0);
        check("nobypass_count", 32'(count_a), 1);
        check("nobypass_unf", 32'(unf_a), 1);
        check("nobypass_data", 32'(pop_data_a), 32'h A5);

        // Flush beats push; reset beats push.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 8'(8'h40 + i), 0, 0, 0, 0);
        cycle(1, 8'h99, 0, 1, 0, 0);
        check("flush_count", 32'(count_a), 0);
        cycle(1, 8'h5A, 0, 0, 0, 0);
        check("after_flush_data", 32'(pop_data_a), 32'h5A);
        cycle(1, 8'h77, 0, 0, 0, 1);
        check("rst_push_count", 32'(count_a), 0);
        check("rst_push_full", 32'(full_a), 0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(99) < 60) ? 1'b1 : 1'b0, 8'($urandom),
                  ($urandom_range(99) < 50) ? 1'b1 : 1'b0,
                  ($urandom_range(99) < 3) ? 1'b1 : 1'b0,
                  ($urandom_range(99) < 6) ? 1'b1 : 1'b0,
                  ($urandom_range(99) < 1) ? 1'b1 : 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sfifo_ext.md
SFIFO_EXT -- requirements
Module: sfifo_ext

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter WIDTH, default 32: data width in bits, at least 1.
REQ-003 Parameter DEPTH, default 32: number of entries, any integer of at least 2 (a power of two is not required).
REQ-004 Parameter AF_THRESH, default DEPTH-2: almost_full asserts when count is at or above this value; legal range 1..DEPTH.
REQ-005 Parameter AE_THRESH, default 2: almost_empty asserts when count is at or below this value; legal range 0..DEPTH-1.
REQ-006 Parameter PASS_ON_FULL, default 1: when 1, a push to a full FIFO is accepted if a pop is accepted in the same cycle.
REQ-007 The ports SHALL be, in this order:
- clk, input, 1: clock.
- rst, input, 1: synchronous active-high reset.
- push, input, 1: request to write push_data.
- push_data, input, WIDTH: write data.
- full, output, 1: count equals DEPTH.
- almost_full, output, 1: count is at or above AF_THRESH.
- pop, input, 1: request to consume the head entry.
- pop_data, output, WIDTH: head entry, first-word-fall-through.
- empty, output, 1: count equals 0.
- almost_empty, output, 1: count is at or below AE_THRESH.
- count, output, $clog2(DEPTH+1): current occupancy.
- flush, input, 1: synchronous clear.
- overflow, output, 1: sticky flag, a push was rejected.
- underflow, output, 1: sticky flag, a pop was rejected.
- clr_err, input, 1: clears overflow and underflow.

Function
REQ-008 pop_data SHALL equal mem[rd_ptr] combinationally, valid whenever empty is 0, and undefined when empty is 1.
REQ-009 A pop SHALL be accepted (pop_acc) when pop is 1 and empty is 0.
REQ-010 A push SHALL be accepted (push_acc) when push is 1 and either full is 0, or PASS_ON_FULL is 1 and pop_acc is 1.
REQ-011 On push_acc, the block SHALL write push_data to mem[wr_ptr] and advance wr_ptr; on pop_acc, it SHALL advance rd_ptr; both updates take effect at the next edge.
REQ-012 Pointers SHALL wrap from DEPTH-1 to 0 for every DEPTH, including non-power-of-two values.
REQ-013 count SHALL change at the next edge by +1 (push_acc only), -1 (pop_acc only), or 0 (both accepted, or neither).
REQ-014 A push to an empty FIFO SHALL NOT bypass to pop_data in the same cycle; a pop issued in that cycle is rejected and the data appears on pop_data one cycle later.
REQ-015 full, almost_full, empty and almost_empty SHALL be decoded combinationally from the registered count.
REQ-016 overflow SHALL set at the next edge when push is 1 and push_acc is 0; underflow SHALL set at the next edge when pop is 1 and pop_acc is 0.
REQ-017 clr_err SHALL clear both sticky flags at the next edge, except that an error condition in the same cycle wins and the corresponding flag remains set.
REQ-018 flush SHALL take priority over push and pop: pointers, count and both error flags clear at the next edge, and no write and no error occurs in that cycle.
REQ-019 Memory contents SHALL NOT be reset or flushed; only pointers define validity.

Reset
REQ-020 When rst is 1 at an edge, the block SHALL set wr_ptr, rd_ptr, count, overflow and underflow to 0; rst overrides flush, push and pop.
REQ-021 After reset, the outputs SHALL be: empty=1, almost_empty=1, full=0, almost_full=0, count=0, overflow=0, underflow=0.

Structure
REQ-022 Package fifo_pkg SHALL hold the ptr_inc(ptr, depth) wrap function and the parameter-legality checks, used by the elaboration-time assertions on AF_THRESH and AE_THRESH.
REQ-023 Storage SHALL be the single sub-module sfifo_ram: a simple dual-port memory with registered write and asynchronous read, carrying a block-RAM style hint.
REQ-024 Control (pointers, count, flags) SHALL reside in sfifo_ext itself; the block is single-clock and contains no clock-domain crossing.

Verification (WIDTH=8, DEPTH=5, AF_THRESH=4, AE_THRESH=1, PASS_ON_FULL=1 unless stated)
REQ-025 Push 0x11..0x15 in 5 cycles -> full=1 and almost_full from count 4; then pop 5 times -> 0x11..0x15 in order, empty=1, and pointers wrapped past 4.
REQ-026 Fill to full, then push 0x66 together with a pop -> head 0x11 consumed, 0x66 stored, full stays 1, overflow=0; repeat with PASS_ON_FULL=0 -> 0x66 dropped, overflow=1, count=4.
REQ-027 Pop when empty -> underflow=1 and count stays 0; assert clr_err together with a second empty pop -> underflow stays 1; assert clr_err alone -> underflow=0.
REQ-028 Push and pop in the same cycle on an empty FIFO with data 0xA5 -> count=1, underflow=1, and pop_data=0xA5 on the next cycle.
REQ-029 With count=3, assert flush together with a push -> count=0, empty=1, no write; then assert rst with push=1 -> count=0 and all flags at their reset values.
